mips32_mem_arbiter: RTL and testbench

- Single-port memory arbiter for the pipe_MIPS32 core. Shares one unified instruction/data memory between two requesters: the IF-stage fetch port (read-only) and the MEM-stage load/store port (read/write).
- Sequences each access through a fixed-latency memory and returns data to the owning requester.
- Honours the core's HALTED flag.
- Prevents fetch starvation with a bounded-priority counter.

---
 rtl/mips32_mem_pkg.sv | 21 ++
 rtl/mips32_arb_pick.sv | 16 +
 rtl/mips32_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips32_mem_pkg.sv
// Shared constants and encodings for the pipe_MIPS32 unified-memory arbiter.
package mips32_mem_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mips32_arb_pick.sv
// Combinational arbitration decision: data port normally beats fetch, except
// when fetch has lost often enough that the starvation limit forces it through.
module mips32_arb_pick
    import mips32_mem_pkg::*;
(
    input  logic   if_elig,
    input  logic   dm_req,
    input  logic   starve_hit,
    output logic   grant_valid,
    output owner_t owner
);

    assign grant_valid = if_elig | dm_req;
    assign owner       = (dm_req && !(if_elig && starve_hit)) ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter sharing one fixed-latency memory between the
// IF fetch port and the MEM load/store port. One transaction in flight.
// Optional wait-cycle statistics are enabled by defining MIPS32_MEM_ARB_STATS_EN.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef MIPS32_MEM_ARB_STATS_EN
    output logic [31:0]   stat_if_wait,
    output logic [31:0]   stat_dm_wait,
`endif
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q;
    owner_t        owner_q;
    logic          we_q;
    logic [3:0]    lat_cnt_q;
    logic [3:0]    starve_q;
    logic          if_gnt_q, dm_gnt_q, if_rvalid_q, dm_rvalid_q;
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          if_elig_d;
    logic          grant_valid_d;
    owner_t        pick_owner_d;

    // A halted core may not start new fetches; in-flight ones still finish.
    assign if_elig_d = if_req & ~halted;

    mips32_arb_pick u_pick (
        .if_elig     (if_elig_d),
        .dm_req      (dm_req),
        .starve_hit  (starve_q == STARVE_LIM),
        .grant_valid (grant_valid_d),
        .owner       (pick_owner_d)
    );

    // Main sequencer: arbitration in IDLE, strobe in ACCESS, latency countdown,
    // one-cycle response. Pulse outputs default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            lat_cnt_q   <= '0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        owner_q  <= pick_owner_d;
                        state_q  <= ST_ACCESS;
                        mem_en_q <= 1'b1;
                        if (pick_owner_d == OWN_DM) begin
                            dm_gnt_q    <= 1'b1;
                            we_q        <= dm_we;
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                            // Only a fetch that actually competed and lost counts.
                            if (if_elig_d) begin
                                starve_q <= starve_q + 4'd1;
                            end
                        end else begin
                            if_gnt_q   <= 1'b1;
                            we_q       <= 1'b0;
                            mem_addr_q <= if_addr;
                            starve_q   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    lat_cnt_q <= LAT_LOAD;
                    if (MEM_LAT == 1) begin
                        state_q     <= ST_RESP;
                        if_rvalid_q <= (owner_q == OWN_IF);
                        dm_rvalid_q <= (owner_q == OWN_DM);
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q <= 4'd1) begin
                        state_q     <= ST_RESP;
                        if_rvalid_q <= (owner_q == OWN_IF);
                        dm_rvalid_q <= (owner_q == OWN_DM);
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Read data arrives in the response cycle itself, so it is passed through
    // gated by the valid pulse; store acks return zero.
    assign if_rdata = if_rvalid_q ? mem_rdata : '0;
    assign dm_rdata = (dm_rvalid_q && !we_q) ? mem_rdata : '0;

`ifdef MIPS32_MEM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_dm_q;

    // Saturating counts of cycles each requester spends asking without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_if_q <= '0;
            stat_dm_q <= '0;
        end else begin
            if (if_req && !if_gnt_q && (stat_if_q != 32'hFFFF_FFFF)) begin
                stat_if_q <= stat_if_q + 32'd1;
            end
            if (dm_req && !dm_gnt_q && (stat_dm_q != 32'hFFFF_FFFF)) begin
                stat_dm_q <= stat_dm_q + 32'd1;
            end
        end
    end

    assign stat_if_wait = stat_if_q;
    assign stat_dm_wait = stat_dm_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed testbench for mips32_mem_arbiter with MEM_LAT=2, STARVE_MAX=3.
module tb_mips32_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, halted;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MIPS32_MEM_ARB_STATS_EN
    logic [31:0]   stat_if_wait, stat_dm_wait;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
`ifdef MIPS32_MEM_ARB_STATS_EN
        .stat_if_wait(stat_if_wait), .stat_dm_wait(stat_dm_wait),
`endif
        .mem_rdata(mem_rdata)
    );

    // Two-stage memory: data for an access strobed in cycle C is valid in C+2.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic [DW-1:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= mem_arr[mem_addr];
        pipe2 <= pipe1;
        if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = pipe2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until a grant appears; who = 0 (IF), 1 (DM) or -1 on timeout.
    task automatic wait_gnt(output int who);
        bit found;
        who   = -1;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (if_gnt === 1'b1) begin who = 0; found = 1'b1; end
            else if (dm_gnt === 1'b1) begin who = 1; found = 1'b1; end
        end
    endtask

    initial begin
        int who, exp_who, n_if_g, n_dm_g, n_dm_ok, n_bad;
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
        mem_arr[10'h005] = 32'h0022_2000;
        mem_arr[10'h008] = 32'h0000_000A;

        // Reset held 3 cycles with both requests pending.
        rst = 1'b1; halted = 1'b0;
        if_req = 1'b1; if_addr = 10'h005;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h008; dm_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_ctrl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we}, 6'b0);
            chk("reset_data", {mem_addr, if_rdata, dm_rdata}, '0);
        end
        rst = 1'b0;

        // Contention: DM load wins the first arbitration after reset.
        tick();
        chk("cont_dm_gnt", {dm_gnt, if_gnt}, 2'b10);
        chk("cont_dm_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h008});
        dm_req = 1'b0;
        tick();
        chk("wait_quiet", {mem_en, mem_we, dm_rvalid, if_rvalid}, 4'b0);
        tick();
        chk("cont_dm_rvalid", {dm_rvalid, if_rvalid}, 2'b10);
        chk("cont_dm_rdata", dm_rdata, 32'h0000_000A);

        // IF read: granted at the next IDLE arbitration.
        tick();
        chk("idle_no_gnt", {if_gnt, dm_gnt}, 2'b00);
        tick();
        chk("if_gnt", {if_gnt, dm_gnt}, 2'b10);
        chk("if_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h005});
        if_req = 1'b0;
        tick();
        chk("if_wait_rvalid", if_rvalid, 1'b0);
        tick();
        chk("if_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
        chk("if_rdata", if_rdata, 32'h0022_2000);
        tick();

        // Starvation: DM held continuously -> D,D,D,I repeating.
        if_req = 1'b1; dm_req = 1'b1;
        for (int t = 0; t < 8; t++) begin
            wait_gnt(who);
            exp_who = (t % 4 == 3) ? 0 : 1;
            chk($sformatf("starve_owner_%0d", t), 64'(who), 64'(exp_who));
            if (t == 7) begin if_req = 1'b0; dm_req = 1'b0; end
            tick();
            tick();
            if (exp_who == 0) begin
                chk("starve_if_resp", {if_rvalid, if_rdata}, {1'b1, 32'h0022_2000});
            end else begin
                chk("starve_dm_resp", {dm_rvalid, dm_rdata}, {1'b1, 32'h0000_000A});
            end
        end
        tick();

        // Store to 0x010.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h010; dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("st_gnt", {dm_gnt, if_gnt}, 2'b10);
        chk("st_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF});
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        chk("st_wait_mem", {mem_en, mem_we, mem_addr}, {1'b0, 1'b0, 10'h010});
        tick();
        chk("st_ack", {dm_rvalid, dm_rdata}, {1'b1, 32'h0});
        tick();

        // Halted: fetch blocked for 20 cycles, DM loads of 0x010 still served.
        halted = 1'b1; if_req = 1'b1; if_addr = 10'h005;
        dm_req = 1'b1; dm_addr = 10'h010;
        n_if_g = 0; n_dm_g = 0; n_dm_ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_gnt === 1'b1) n_if_g++;
            if (dm_gnt === 1'b1) n_dm_g++;
            if (dm_rvalid === 1'b1 && dm_rdata === 32'hDEAD_BEEF) n_dm_ok++;
        end
        chk("halt_if_gnts", 64'(n_if_g), 64'd0);
        chk("halt_dm_gnts", 64'(n_dm_g), 64'd5);
        chk("halt_dm_loads", 64'(n_dm_ok), 64'd5);

        // Release halt, start a fetch, then reset during WAIT.
        dm_req = 1'b0; halted = 1'b0;
        tick();
        chk("pre_rst_if_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_ctrl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we}, 6'b0);
        rst = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) n_bad++;
        end
        chk("midrst_no_rvalid", 64'(n_bad), 64'd0);

        // Back in IDLE: a fresh fetch is accepted immediately.
        if_req = 1'b1; if_addr = 10'h008;
        tick();
        chk("post_rst_gnt", {if_gnt, mem_en, mem_addr}, {1'b1, 1'b1, 10'h008});
        if_req = 1'b0;
        tick();
        tick();
        chk("post_rst_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h0000_000A});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
